// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream and downstream valid/ready/data plus occupancy.
// Handshake rule: a transfer happens on a rising clk edge exactly when valid and ready are both 1;
// once valid is raised it and its data are held until that transfer happens.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
);
    localparam int OCC_W = $clog2(2 * DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occ;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occ
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occ
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: DEPTH cascaded skid-buffer stages (main + skid slot each),
// ready is registered per stage so no combinational ready path spans the chain.
module pipe_skid_reg #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    pipe_skid_reg_if.slave bus
);
    localparam int OCC_W = $clog2(2 * DEPTH + 1);

    logic [DEPTH-1:0] mv_w;
    logic [DEPTH-1:0] sv_w;
    logic [WIDTH-1:0] md_w [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             m_v;
        logic             s_v;
        logic [WIDTH-1:0] m_d;
        logic [WIDTH-1:0] s_d;
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn_rdy;
        logic             in_fire;
        logic             out_fire;

        if (i == 0) begin : g_first
            assign up_v = bus.in_valid;
            assign up_d = bus.in_data;
        end else begin : g_mid
            assign up_v = mv_w[i-1];
            assign up_d = md_w[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign dn_rdy = bus.out_ready;
        end else begin : g_inner
            assign dn_rdy = ~sv_w[i+1];
        end

        // Ready towards upstream is just "skid slot empty", a pure register.
        assign in_fire  = up_v & ~s_v;
        assign out_fire = m_v & dn_rdy;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_v <= 1'b0;
                s_v <= 1'b0;
                m_d <= '0;
                s_d <= '0;
            end else if (flush) begin
                m_v <= 1'b0;
                s_v <= 1'b0;
            end else if (out_fire && s_v) begin
                m_d <= s_d;
                s_v <= 1'b0;
            end else if (out_fire) begin
                m_v <= in_fire;
                if (in_fire) m_d <= up_d;
            end else if (!m_v) begin
                if (in_fire) begin
                    m_v <= 1'b1;
                    m_d <= up_d;
                end
            end else if (in_fire) begin
                s_v <= 1'b1;
                s_d <= up_d;
            end
        end

        assign mv_w[i] = m_v;
        assign sv_w[i] = s_v;
        assign md_w[i] = m_d;

        a_skid_implies_main: assert property (
            @(posedge clk) disable iff (!rst_n) s_v |-> m_v
        );
    end

    logic             top_in_fire;
    logic             top_out_fire;
    logic [OCC_W-1:0] occ_q;

    assign top_in_fire  = bus.in_valid & ~sv_w[0];
    assign top_out_fire = mv_w[DEPTH-1] & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(top_in_fire) - OCC_W'(top_out_fire);
        end
    end

    assign bus.in_ready  = ~sv_w[0];
    assign bus.out_valid = mv_w[DEPTH-1];
    assign bus.out_data  = md_w[DEPTH-1];
    assign bus.occ       = occ_q;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised checks of pipe_skid_reg at DEPTH=2/WIDTH=16 and the DEPTH=1/WIDTH=1 corner.
module tb_pipe_skid_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush_b = 1'b0;

    int total_cnt = 0;
    int pass_cnt = 0;

    logic [15:0] exp_q[$];
    logic [0:0]  exp_b_q[$];

    always #5 clk = ~clk;

    pipe_skid_reg_if #(.WIDTH(16), .DEPTH(2)) bus_a ();
    pipe_skid_reg_if #(.WIDTH(1),  .DEPTH(1)) bus_b ();

    pipe_skid_reg #(.WIDTH(16), .DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a.slave)
    );
    pipe_skid_reg #(.WIDTH(1), .DEPTH(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus_a.in_ready); else pass_cnt++;
        total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus_a.out_valid); else pass_cnt++;
        total_cnt++; if (bus_a.out_data !== 16'h0) $display("FAIL rst_out_data: got %h want 0000", bus_a.out_data); else pass_cnt++;
        total_cnt++; if (bus_a.occ !== 3'd0) $display("FAIL rst_occ: got %0d want 0", bus_a.occ); else pass_cnt++;
        total_cnt++; if (bus_b.in_ready !== 1'b1) $display("FAIL rst_b_in_ready: got %b want 1", bus_b.in_ready); else pass_cnt++;
        total_cnt++; if (bus_b.occ !== 2'd0) $display("FAIL rst_b_occ: got %0d want 0", bus_b.occ); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        // Fill three entries, then pull reset between edges.
        bus_a.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = 16'h0011 * 16'(k + 1);
            tick();
        end
        bus_a.in_valid = 1'b0;
        total_cnt++; if (bus_a.occ !== 3'd3) $display("FAIL pre_rst_occ: got %0d want 3", bus_a.occ); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL async_rst_in_ready: got %b want 1", bus_a.in_ready); else pass_cnt++;
        total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL async_rst_out_valid: got %b want 0", bus_a.out_valid); else pass_cnt++;
        total_cnt++; if (bus_a.out_data !== 16'h0) $display("FAIL async_rst_out_data: got %h want 0000", bus_a.out_data); else pass_cnt++;
        total_cnt++; if (bus_a.occ !== 3'd0) $display("FAIL async_rst_occ: got %0d want 0", bus_a.occ); else pass_cnt++;
        tick();
        #2 rst_n = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 16'h00AA;
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL post_rst_lat1_valid: got %b want 0", bus_a.out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (bus_a.out_valid !== 1'b1) $display("FAIL post_rst_lat2_valid: got %b want 1", bus_a.out_valid); else pass_cnt++;
        total_cnt++; if (bus_a.out_data !== 16'h00AA) $display("FAIL post_rst_data: got %h want 00aa", bus_a.out_data); else pass_cnt++;
        tick();
        total_cnt++; if (bus_a.occ !== 3'd0) $display("FAIL post_rst_drain_occ: got %0d want 0", bus_a.occ); else pass_cnt++;
    endtask

    task automatic test_streaming;
        logic       exp_v;
        logic [2:0] exp_occ;
        bus_a.out_ready = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            bus_a.in_valid = (n <= 16);
            bus_a.in_data  = 16'(n);
            if (n <= 16) begin
                total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL stream_in_ready n=%0d: got %b want 1", n, bus_a.in_ready); else pass_cnt++;
            end
            tick();
            exp_v   = (n >= 2) && (n <= 17);
            exp_occ = (n <= 16) ? ((n < 2) ? 3'(n) : 3'd2) : 3'(18 - n);
            total_cnt++; if (bus_a.out_valid !== exp_v) $display("FAIL stream_valid n=%0d: got %b want %b", n, bus_a.out_valid, exp_v); else pass_cnt++;
            if (exp_v) begin
                total_cnt++; if (bus_a.out_data !== 16'(n - 1)) $display("FAIL stream_data n=%0d: got %h want %h", n, bus_a.out_data, 16'(n - 1)); else pass_cnt++;
            end
            total_cnt++; if (bus_a.occ !== exp_occ) $display("FAIL stream_occ n=%0d: got %0d want %0d", n, bus_a.occ, exp_occ); else pass_cnt++;
        end
        bus_a.in_valid = 1'b0;
    endtask

    task automatic test_full_stall;
        bus_a.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = 16'h0100 + 16'((k < 4) ? k : 4);
            total_cnt++; if (bus_a.in_ready !== (k < 4)) $display("FAIL stall_in_ready k=%0d: got %b want %b", k, bus_a.in_ready, (k < 4)); else pass_cnt++;
            tick();
            if (k >= 1) begin
                total_cnt++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'h0100) $display("FAIL stall_hold k=%0d: got v=%b d=%h want v=1 d=0100", k, bus_a.out_valid, bus_a.out_data); else pass_cnt++;
            end
        end
        bus_a.in_valid = 1'b0;
        total_cnt++; if (bus_a.occ !== 3'd4) $display("FAIL stall_occ_full: got %0d want 4", bus_a.occ); else pass_cnt++;
        bus_a.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            total_cnt++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'h0100 + 16'(j)) $display("FAIL drain_data j=%0d: got v=%b d=%h want v=1 d=%h", j, bus_a.out_valid, bus_a.out_data, 16'h0100 + 16'(j)); else pass_cnt++;
            tick();
            if (j == 0) begin
                total_cnt++; if (bus_a.in_ready !== 1'b0) $display("FAIL drain_ready_d1: got %b want 0", bus_a.in_ready); else pass_cnt++;
            end
            if (j == 1) begin
                total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL drain_ready_d2: got %b want 1", bus_a.in_ready); else pass_cnt++;
            end
        end
        total_cnt++; if (bus_a.occ !== 3'd0 || bus_a.out_valid !== 1'b0) $display("FAIL drain_empty: got occ=%0d v=%b want occ=0 v=0", bus_a.occ, bus_a.out_valid); else pass_cnt++;
    endtask

    task automatic test_flush;
        bus_a.out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = 16'h0A00 + 16'(k);
            tick();
        end
        bus_a.in_valid = 1'b0;
        total_cnt++; if (bus_a.occ !== 3'd3) $display("FAIL flush_pre_occ: got %0d want 3", bus_a.occ); else pass_cnt++;
        flush           = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 16'hBEEF;
        bus_a.out_ready = 1'b1;
        total_cnt++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'h0A01) $display("FAIL flush_head: got v=%b d=%h want v=1 d=0a01", bus_a.out_valid, bus_a.out_data); else pass_cnt++;
        total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", bus_a.in_ready); else pass_cnt++;
        tick();
        flush          = 1'b0;
        bus_a.in_valid = 1'b0;
        total_cnt++; if (bus_a.occ !== 3'd0) $display("FAIL flush_occ: got %0d want 0", bus_a.occ); else pass_cnt++;
        total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", bus_a.out_valid); else pass_cnt++;
        total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL flush_ready_after: got %b want 1", bus_a.in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (bus_a.out_valid !== 1'b0 || bus_a.occ !== 3'd0) $display("FAIL flush_discard: got v=%b occ=%0d want v=0 occ=0", bus_a.out_valid, bus_a.occ); else pass_cnt++;
    endtask

    task automatic test_random;
        int   cnt;
        logic push;
        logic pop;
        cnt = 0;
        exp_q.delete();
        for (int c = 0; c < 10000; c++) begin
            bus_a.in_valid  = 1'($urandom_range(0, 1));
            bus_a.in_data   = 16'($urandom_range(0, 65535));
            bus_a.out_ready = 1'($urandom_range(0, 1));
            if (cnt == 4) begin
                total_cnt++; if (bus_a.in_ready !== 1'b0) $display("FAIL rand_full_ready c=%0d: got %b want 0", c, bus_a.in_ready); else pass_cnt++;
            end
            if (cnt == 0) begin
                total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL rand_empty_valid c=%0d: got %b want 0", c, bus_a.out_valid); else pass_cnt++;
            end
            if (bus_a.out_valid === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL rand_spurious c=%0d: got d=%h want no item", c, bus_a.out_data);
                else if (bus_a.out_data !== exp_q[0]) $display("FAIL rand_data c=%0d: got %h want %h", c, bus_a.out_data, exp_q[0]);
                else pass_cnt++;
            end
            push = bus_a.in_valid && (bus_a.in_ready === 1'b1);
            pop  = (bus_a.out_valid === 1'b1) && bus_a.out_ready;
            tick();
            if (push) begin
                exp_q.push_back(bus_a.in_data);
                cnt++;
            end
            if (pop && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                cnt--;
            end
            total_cnt++; if (bus_a.occ !== 3'(cnt)) $display("FAIL rand_occ c=%0d: got %0d want %0d", c, bus_a.occ, cnt); else pass_cnt++;
        end
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        for (int d = 0; d < 8; d++) begin
            if (bus_a.out_valid === 1'b1 && exp_q.size() > 0) begin
                total_cnt++; if (bus_a.out_data !== exp_q[0]) $display("FAIL rand_tail_data: got %h want %h", bus_a.out_data, exp_q[0]); else pass_cnt++;
                void'(exp_q.pop_front());
            end
            tick();
        end
        total_cnt++; if (exp_q.size() != 0) $display("FAIL rand_leftover: got %0d items undelivered want 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_depth1;
        int   cnt;
        logic push;
        logic pop;
        cnt = 0;
        exp_b_q.delete();
        for (int c = 0; c < 40; c++) begin
            bus_b.in_valid  = 1'b1;
            bus_b.in_data   = 1'($urandom_range(0, 1));
            bus_b.out_ready = c[0];
            total_cnt++; if (bus_b.in_ready !== (cnt != 2)) $display("FAIL d1_in_ready c=%0d: got %b want %b", c, bus_b.in_ready, (cnt != 2)); else pass_cnt++;
            total_cnt++; if (bus_b.out_valid !== (cnt != 0)) $display("FAIL d1_out_valid c=%0d: got %b want %b", c, bus_b.out_valid, (cnt != 0)); else pass_cnt++;
            if (bus_b.out_valid === 1'b1 && exp_b_q.size() > 0) begin
                total_cnt++; if (bus_b.out_data !== exp_b_q[0]) $display("FAIL d1_data c=%0d: got %b want %b", c, bus_b.out_data, exp_b_q[0]); else pass_cnt++;
            end
            push = bus_b.in_ready === 1'b1;
            pop  = (bus_b.out_valid === 1'b1) && bus_b.out_ready;
            tick();
            if (push) begin
                exp_b_q.push_back(bus_b.in_data);
                cnt++;
            end
            if (pop && exp_b_q.size() > 0) begin
                void'(exp_b_q.pop_front());
                cnt--;
            end
            total_cnt++; if (bus_b.occ !== 2'(cnt) || cnt > 2) $display("FAIL d1_occ c=%0d: got %0d want %0d", c, bus_b.occ, cnt); else pass_cnt++;
        end
        bus_b.in_valid = 1'b0;
    endtask

    initial begin
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.out_ready = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.in_data   = '0;
        bus_b.out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_full_stall();
        test_flush();
        test_random();
        test_depth1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
